binary_to_bcd: RTL and testbench
================================

// Module: binary_to_bcd
// PURPOSE
//  Multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble).
//  Converts an 8-bit unsigned value to two packed BCD digits (tens, units).
//  Used by the Pong score path to drive the decimal score display.
//  Start/completed handshake; the result is held until the next conversion.
// PARAMETERS
//  None. Widths are fixed: 8-bit binary input, 2 BCD digits (8-bit output).
// PORTS
//  clock      in   1  system clock; all state updates on the rising edge
//  reset      in   1  asynchronous, active-high reset
//  start      in   1  conversion request; rising-edge triggered
//  binary     in   8  unsigned value to convert; sampled only at accept
//  bcd        out  8  [7:4] tens digit, [3:0] units digit; registered
//  completed  out  1  high while bcd holds a finished result
// BEHAVIOUR
//  - Reset (async, high):
//    - state=IDLE; bcd=8'h00; completed=0.
//    - start_d=0, scratch=0, cnt=0.
//  - start_d: a one-cycle registered copy of start.
//  - Accept: rising edge of start = start & ~start_d.
//    - Accepted only in IDLE or DONE; edges in SHIFT are ignored and lost.
//    - Start held high for many cycles triggers exactly one conversion.
//  - States:
//    - IDLE: wait for accept.
//    - SHIFT: 8 iterations, one per cycle.
//    - DONE: hold result; accept -> SHIFT.
//  - At accept (edge N):
//    - scratch[15:0] <= {8'h00, binary}; cnt <= 0; completed <= 0.
//    - bcd keeps its previous value.
//  - Each SHIFT cycle, combinationally:
//    - add 3 to each BCD nibble (scratch[15:12], scratch[11:8]) that is >= 5;
//    - then shift scratch left by 1 and register it; cnt <= cnt + 1.
//  - After the 8th shift (edge N+8):
//    - bcd <= scratch[15:8] (post-shift value); completed <= 1; state DONE.
//    - Latency from accept to a valid result is 8 clocks.
//  - Range: inputs 0..99 convert exactly.
//    - Inputs 100..255 yield (value mod 100); the hundreds carry shifted out
//      of the tens nibble is discarded by design.
//  - binary changes after accept have no effect on the running conversion.
//  - completed stays high in DONE until the next accept clears it.
//  - Reset during SHIFT aborts the conversion: outputs return to reset values.
//  - No X on outputs after reset; every bcd nibble is always 0..9.
// STRUCTURE
//  - Shared package (pong_pkg):
//    - BIN_W=8, BCD_DIGITS=2;
//    - state enum {IDLE, SHIFT, DONE} (2-bit encoding).
//  - Sub-module bcd_add3: 4-bit in, 4-bit out, combinational.
//    - out = (in >= 5) ? in + 3 : in; one instance per digit.
//  - Top: start edge detector, FSM, 16-bit scratch register,
//    3-bit iteration counter, output registers.
// TESTING
//  1. Reset, then binary=11 with start high for 2 clocks
//     -> completed rises 8 clocks after accept; bcd=8'h11.
//  2. Then binary=7 and pulse start
//     -> completed drops at accept; bcd stays 8'h11 during SHIFT;
//        bcd=8'h07 and completed=1 after 8 clocks.
//  3. Sweep 0, 9, 10, 99 -> 8'h00, 8'h09, 8'h10, 8'h99.
//     Inputs 100 and 255 -> 8'h00 and 8'h55 (mod 100).
//  4. Hold start high for 50 clocks with binary=42
//     -> exactly one completed rise; bcd=8'h42.
//     A second start edge during SHIFT is ignored and the result is unchanged.
//  5. Assert reset at SHIFT iteration 4
//     -> bcd=0 and completed=0 immediately (async).
//     Next start with binary=58 -> bcd=8'h58.
//  6. Change binary from 23 to 99 one cycle after accept -> bcd=8'h23.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared widths, state encoding and derived constants for the Pong score path.
package pong_pkg;
  localparam int BIN_W      = 8;
  localparam int BCD_DIGITS = 2;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int SCRATCH_W  = BCD_W + BIN_W;
  localparam int CNT_W      = $clog2(BIN_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added so the
// following left shift carries it correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);
  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/binary_to_bcd.sv
// Multi-cycle 8-bit binary to two-digit BCD converter (shift-and-add-3).
// One shift per clock; the result is held with completed high until the next start edge.
module binary_to_bcd
  import pong_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] binary,
  output logic [BCD_W-1:0] bcd,
  output logic             completed
);
  state_e               state_q;
  logic                 start_prev_q;
  logic [SCRATCH_W-1:0] scratch_q, scratch_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           tens_adj, units_adj;
  logic                 accept;

  bcd_add3 u_tens (.digit_i(scratch_q[15:12]), .digit_o(tens_adj));
  bcd_add3 u_units(.digit_i(scratch_q[11:8]),  .digit_o(units_adj));

  assign accept = start & ~start_prev_q;

  // Correct both digits first, then shift; any hundreds carry falls off the top.
  always_comb begin
    scratch_d = {tens_adj, units_adj, scratch_q[BIN_W-1:0]} << 1;
  end

  // NOTE: every register here uses <= so all state advances together on the
  // clock edge, and each one has an explicit reset value to keep outputs X-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      scratch_q    <= '0;
      cnt_q        <= '0;
      bcd          <= '0;
      completed    <= 1'b0;
    end else begin
      start_prev_q <= start;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            scratch_q <= {{BCD_W{1'b0}}, binary};
            cnt_q     <= '0;
            completed <= 1'b0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            bcd       <= scratch_d[SCRATCH_W-1:BIN_W];
            completed <= 1'b1;
            state_q   <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_binary_to_bcd.sv
// Directed self-checking bench for binary_to_bcd: latency, hold, edge
// detection, mod-100 wrap, async reset abort and input sampling.
module tb_binary_to_bcd;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] binary = 8'd0;
  logic [7:0] bcd;
  logic       completed;
  int checks = 0;
  int failures = 0;

  binary_to_bcd dut (
    .clock(clock), .reset(reset), .start(start),
    .binary(binary), .bcd(bcd), .completed(completed)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cyc = clock edges already elapsed after the accepting edge; waits for completed.
  task automatic wait_done(input int cyc_in, output int cyc);
    cyc = cyc_in;
    while (!completed && cyc < 30) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  // Raise start with a value at a negedge, keep it high for `hold` clocks.
  task automatic run_conv(input logic [7:0] val, input int hold,
                          input logic [7:0] exp, input string tag);
    int cyc;
    @(negedge clock);
    binary = val;
    start  = 1'b1;
    for (int i = 0; i < hold; i++) @(negedge clock);
    start = 1'b0;
    wait_done(hold - 1, cyc);
    check({tag, "_latency"}, cyc, 8);
    check({tag, "_bcd"}, bcd, exp);
  endtask

  initial begin
    int cyc;
    int rises;
    logic prev;

    // Reset state
    @(negedge clock);
    check("reset_bcd", bcd, 8'h00);
    check("reset_completed", completed, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle_completed", completed, 0);

    // 1. start held for two clocks
    run_conv(8'd11, 2, 8'h11, "t1_11");
    check("t1_completed", completed, 1);

    // 2. completed drops at accept, bcd holds old result during SHIFT
    @(negedge clock);
    binary = 8'd7;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("t2_completed_drop", completed, 0);
    check("t2_bcd_hold_a", bcd, 8'h11);
    repeat (3) @(negedge clock);
    check("t2_bcd_hold_b", bcd, 8'h11);
    wait_done(3, cyc);
    check("t2_latency", cyc, 8);
    check("t2_bcd", bcd, 8'h07);
    repeat (3) @(negedge clock);
    check("t2_hold_completed", completed, 1);
    check("t2_hold_bcd", bcd, 8'h07);

    // 3. sweep, including mod-100 wrap
    run_conv(8'd0,   1, 8'h00, "t3_0");
    run_conv(8'd9,   1, 8'h09, "t3_9");
    run_conv(8'd10,  1, 8'h10, "t3_10");
    run_conv(8'd99,  1, 8'h99, "t3_99");
    run_conv(8'd100, 1, 8'h00, "t3_100");
    run_conv(8'd255, 1, 8'h55, "t3_255");

    // 4. start held 50 clocks -> one conversion only
    @(negedge clock);
    binary = 8'd42;
    start  = 1'b1;
    prev   = completed;
    rises  = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (completed && !prev) rises++;
      prev = completed;
    end
    start = 1'b0;
    check("t4_rises", rises, 1);
    check("t4_bcd", bcd, 8'h42);

    // 4b. a second start edge during SHIFT is ignored
    @(negedge clock);
    binary = 8'd37;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    binary = 8'd99;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(2, cyc);
    check("t4b_latency", cyc, 8);
    check("t4b_bcd", bcd, 8'h37);
    repeat (12) @(negedge clock);
    check("t4b_no_restart_bcd", bcd, 8'h37);
    check("t4b_no_restart_completed", completed, 1);

    // 5. reset mid-conversion clears outputs immediately
    @(negedge clock);
    binary = 8'd64;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("t5_reset_bcd", bcd, 8'h00);
    check("t5_reset_completed", completed, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    check("t5_aborted_completed", completed, 0);
    run_conv(8'd58, 1, 8'h58, "t5_58");

    // 6. binary changes after accept do not disturb the conversion
    @(negedge clock);
    binary = 8'd23;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    binary = 8'd99;
    wait_done(0, cyc);
    check("t6_latency", cyc, 8);
    check("t6_bcd", bcd, 8'h23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
